// File: rtl/char_osd_seq.sv
// Walks a text string row-major (row 0 of every char, then row 1, ...) and presents each char to the glyph ROM stage.
// Optional OSD_SKIP_BLANK_EN: codes outside 33..126 are consumed without being presented.
module char_osd_seq #(
  parameter int CHAR_W    = 9,
  parameter int CHAR_H    = 18,
  parameter int MAX_CHARS = 64,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [10:0]       cfg_base_x,
  input  logic [10:0]       cfg_base_y,
  input  logic [ADDR_W:0]   cfg_len,
  output logic              busy,
  output logic              done,
  output logic              text_rd_en,
  output logic [ADDR_W-1:0] text_rd_addr,
  input  logic [7:0]        text_rd_data,
  output logic [7:0]        char_ascii,
  output logic [5:0]        char_row_index,
  output logic [10:0]       char_pos_x,
  output logic [10:0]       char_pos_y,
  output logic              char_valid,
  input  logic              char_next
);

  typedef enum logic [2:0] {IDLE, FETCH, CAPT, PRESENT, FIN} state_t;

  localparam logic [ADDR_W:0]   MAX_LEN  = (ADDR_W+1)'(MAX_CHARS);
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = 1;
  localparam logic [5:0]        ROW_LAST = 6'(CHAR_H - 1);
  localparam logic [10:0]       X_STEP   = 11'(CHAR_W);

  state_t            state;
  logic [ADDR_W:0]   len_q;
  logic [10:0]       base_x_q;
  logic [10:0]       base_y_q;
  logic [10:0]       x_acc;
  logic [ADDR_W-1:0] idx;
  logic [5:0]        row;

  logic [ADDR_W:0] cfg_len_c;
  logic            idx_last;
  logic            row_last;
  logic            present_ok;
  logic            advance;

  assign cfg_len_c    = (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
  assign idx_last     = ({1'b0, idx} == (len_q - LEN_ONE));
  assign row_last     = (row == ROW_LAST);
  assign text_rd_addr = idx;

`ifdef OSD_SKIP_BLANK_EN
  assign present_ok = (text_rd_data >= 8'd33) && (text_rd_data <= 8'd126);
`else
  assign present_ok = 1'b1;
`endif

  // A skipped code steps the walk exactly like a consumed character.
  assign advance = ((state == PRESENT) && char_valid && char_next) ||
                   ((state == CAPT) && !present_ok);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      len_q          <= '0;
      base_x_q       <= '0;
      base_y_q       <= '0;
      x_acc          <= '0;
      idx            <= '0;
      row            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      text_rd_en     <= 1'b0;
      char_ascii     <= '0;
      char_row_index <= '0;
      char_pos_x     <= '0;
      char_pos_y     <= '0;
      char_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            base_x_q <= cfg_base_x;
            base_y_q <= cfg_base_y;
            len_q    <= cfg_len_c;
            x_acc    <= cfg_base_x;
            idx      <= '0;
            row      <= '0;
            if (cfg_len_c == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy       <= 1'b1;
              text_rd_en <= 1'b1;
              state      <= FETCH;
            end
          end
        end
        FETCH: begin
          text_rd_en <= 1'b0;
          state      <= CAPT;
        end
        CAPT: begin
          if (present_ok) begin
            char_ascii     <= text_rd_data;
            char_row_index <= row;
            char_pos_x     <= x_acc;
            char_pos_y     <= base_y_q;
            char_valid     <= 1'b1;
            state          <= PRESENT;
          end
        end
        PRESENT: begin
          if (char_valid && char_next) char_valid <= 1'b0;
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (advance) begin
        if (!idx_last) begin
          idx        <= idx + IDX_ONE;
          x_acc      <= x_acc + X_STEP;
          text_rd_en <= 1'b1;
          state      <= FETCH;
        end else if (!row_last) begin
          idx        <= '0;
          x_acc      <= base_x_q;
          row        <= row + 6'd1;
          text_rd_en <= 1'b1;
          state      <= FETCH;
        end else begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= FIN;
        end
      end
    end
  end

endmodule

// File: tb/tb_char_osd_seq.sv
// Randomized bench for char_osd_seq: a text RAM model feeds the DUT and every presentation
// is scored against a queue built from the row-major walk rules.
module tb_char_osd_seq;
  localparam int CHAR_W = 9, CHAR_H = 18, MAX_CHARS = 64, ADDR_W = 6;
`ifdef OSD_SKIP_BLANK_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              start = 1'b0;
  logic [10:0]       cfg_base_x = '0;
  logic [10:0]       cfg_base_y = '0;
  logic [ADDR_W:0]   cfg_len = '0;
  logic              busy, done, text_rd_en, char_valid;
  logic [ADDR_W-1:0] text_rd_addr;
  logic [7:0]        text_rd_data = '0;
  logic [7:0]        char_ascii;
  logic [5:0]        char_row_index;
  logic [10:0]       char_pos_x, char_pos_y;
  logic              char_next = 1'b0;

  char_osd_seq #(.CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .MAX_CHARS(MAX_CHARS), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .cfg_base_x(cfg_base_x), .cfg_base_y(cfg_base_y), .cfg_len(cfg_len),
    .busy(busy), .done(done),
    .text_rd_en(text_rd_en), .text_rd_addr(text_rd_addr), .text_rd_data(text_rd_data),
    .char_ascii(char_ascii), .char_row_index(char_row_index),
    .char_pos_x(char_pos_x), .char_pos_y(char_pos_y),
    .char_valid(char_valid), .char_next(char_next)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [5:0]  r;
    logic [10:0] x;
    logic [10:0] y;
  } pres_t;

  pres_t      exp_q[$];
  logic [7:0] mem [0:MAX_CHARS-1];
  int         n_checks = 0, n_errors = 0;
  int         pres_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int         next_mode = 0;
  pres_t      held, last_pres;
  logic       prev_valid = 1'b0;
  int         age = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Text RAM: one-cycle read latency.
  always @(posedge clk) if (text_rd_en) text_rd_data <= mem[text_rd_addr];

  // ROM-stage model: 0 random pulses (also while idle), 1 always ready, 2 ready on 2nd valid cycle.
  always @(negedge clk) begin
    if (char_valid) age++; else age = 0;
    case (next_mode)
      0: char_next = ($urandom_range(0, 2) == 0);
      1: char_next = 1'b1;
      2: char_next = char_valid && (age == 2);
      default: char_next = 1'b0;
    endcase
  end

  // Monitor: score each rising char_valid, check fields stay stable while valid.
  always @(negedge clk) begin
    if (text_rd_en) rd_cnt++;
    if (done) done_cnt++;
    if (char_valid && !prev_valid) begin
      pres_cnt++;
      held      = {char_ascii, char_row_index, char_pos_x, char_pos_y};
      last_pres = held;
      if (exp_q.size() == 0) check("extra_pres", 1, 0);
      else check("pres", held, exp_q.pop_front());
      check("busy_in_pres", busy, 1);
    end else if (char_valid) begin
      check("hold", {char_ascii, char_row_index, char_pos_x, char_pos_y}, held);
    end
    prev_valid = char_valid;
  end

  task automatic build_model(input int len, input int bx, input int by, output int l_eff);
    pres_t p;
    l_eff = (len > MAX_CHARS) ? MAX_CHARS : len;
    exp_q.delete();
    for (int r = 0; r < CHAR_H; r++)
      for (int i = 0; i < l_eff; i++) begin
        if (SKIP && (mem[i] < 8'd33 || mem[i] > 8'd126)) continue;
        p.a = mem[i];
        p.r = r[5:0];
        p.x = 11'((bx + i * CHAR_W) % 2048);
        p.y = by[10:0];
        exp_q.push_back(p);
      end
  endtask

  task automatic start_run(input int len, input int bx, input int by, input int mode,
                           output int l_eff, output int n_exp);
    build_model(len, bx, by, l_eff);
    n_exp = exp_q.size();
    @(negedge clk);
    pres_cnt = 0; rd_cnt = 0; done_cnt = 0;
    next_mode = mode;
    cfg_base_x = bx[10:0];
    cfg_base_y = by[10:0];
    cfg_len = len[ADDR_W:0];
    start = 1'b1;
  endtask

  // Waits for done, throwing stray start pulses in while busy, then checks the run totals.
  task automatic finish_run(input int l_eff, input int n_exp);
    bit seen = 0;
    for (int c = 0; c < 30000 && !seen; c++) begin
      if (done) seen = 1;
      else begin
        if (busy && $urandom_range(0, 15) == 0) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    check("pres_cnt", pres_cnt, n_exp);
    check("exp_left", exp_q.size(), 0);
    check("rd_cnt", rd_cnt, CHAR_H * l_eff);
    check("done_cnt", done_cnt, 1);
    check("busy_after", busy, 0);
  endtask

  task automatic run_string(input int len, input int bx, input int by, input int mode);
    int l_eff, n_exp;
    start_run(len, bx, by, mode, l_eff, n_exp);
    @(negedge clk);
    start = 1'b0;
    finish_run(l_eff, n_exp);
  endtask

  function automatic logic [45:0] all_outs();
    return {busy, done, text_rd_en, text_rd_addr, char_ascii, char_row_index,
            char_pos_x, char_pos_y, char_valid};
  endfunction

  initial begin
    int l_eff, n_exp, dcnt;
    bit found;
    logic rd_pat [1:6];
    logic v_pat  [1:6];
    rd_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    v_pat  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < MAX_CHARS; i++) mem[i] = 8'd0;

    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // "ABC" at (100,50), consumer answers two cycles into each presentation.
    mem[0] = "A"; mem[1] = "B"; mem[2] = "C";
    run_string(3, 100, 50, 2);
    check("abc_count", pres_cnt, 54);
    check("abc_last", last_pres, {8'h43, 6'd17, 11'd118, 11'd50});

    // Cycle-exact latency with char_next held high.
    start_run(2, 0, 0, 1, l_eff, n_exp);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
      check("lat_rd_en", text_rd_en, rd_pat[k]);
      check("lat_valid", char_valid, v_pat[k]);
    end
    finish_run(l_eff, n_exp);

    // Empty string: immediate done, no reads.
    start_run(0, 5, 5, 0, l_eff, n_exp);
    @(negedge clk);
    start = 1'b0;
    check("len0_done", done, 1);
    check("len0_busy", busy, 0);
    finish_run(l_eff, n_exp);
    check("len0_pres", pres_cnt, 0);

    // X wrap at 11 bits.
    run_string(2, 2040, 7, 0);
    check("wrap_x", last_pres.x, 1);

    // "A B": the space is presented only when blank skipping is off.
    mem[0] = "A"; mem[1] = " "; mem[2] = "B";
    run_string(3, 10, 20, 0);
    check("blank_count", pres_cnt, SKIP ? 36 : 54);
    check("blank_last_x", last_pres.x, 28);

    // All-blank string still completes.
    mem[0] = " "; mem[1] = 8'd200;
    run_string(2, 3, 4, 1);

    // Oversized length clamps to MAX_CHARS.
    for (int i = 0; i < MAX_CHARS; i++) mem[i] = 8'($urandom_range(32, 126));
    run_string(100, $urandom_range(0, 2047), $urandom_range(0, 2047), 1);
    check("clamp_count", rd_cnt, MAX_CHARS * CHAR_H);

    // Reset while presenting row 5 aborts silently.
    start_run(5, 300, 200, 0, l_eff, n_exp);
    found = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (char_valid && char_row_index == 6'd5) found = 1;
    end
    check("row5_reached", found, 1);
    dcnt = done_cnt;
    resetn = 1'b0;
    @(negedge clk);
    check("abort_outs", all_outs(), 0);
    resetn = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_no_done", done_cnt, dcnt);
    run_string(4, 60, 70, 0);

    // Random strings.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < MAX_CHARS; i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? 8'd32 : 8'($urandom_range(0, 255));
      run_string($urandom_range(1, 12), $urandom_range(0, 2047), $urandom_range(0, 2047), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/char_osd_seq.md
Name: char_osd_seq

Overview:
- Sequencer that drives one character-row pixel ROM stage of the char OSD: walks a text string stored in an external text RAM and issues each character row by row.
- Order is row-major: row 0 of char 0..N-1, then row 1, and so on, up to row CHAR_H-1.
- Presents ASCII code, row index and glyph origin to the ROM stage, and advances on that stage's char_next handshake.
- Sits between the UDP-loaded text buffer and the glyph ROM/row-pixel path.

Parameters:
- CHAR_W, 9, glyph width in pixels; also the X step between characters.
- CHAR_H, 18, glyph rows per character; row index runs 0..CHAR_H-1.
- MAX_CHARS, 64, maximum string length.
- ADDR_W, 6, text RAM address width; ceil(log2(MAX_CHARS)).

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a string. Ignored while busy.
- cfg_base_x  in  11  X of the first character's left column.
- cfg_base_y  in  11  Y of glyph row 0.
- cfg_len  in  ADDR_W+1  number of characters; values above MAX_CHARS are clamped to MAX_CHARS.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the string is complete.
- text_rd_en  out  1  text RAM read strobe.
- text_rd_addr  out  ADDR_W  text RAM address, equal to the character index.
- text_rd_data  in  8  ASCII code, valid the cycle after text_rd_en.
- char_ascii  out  8  code presented to the ROM stage.
- char_row_index  out  6  current glyph row.
- char_pos_x  out  11  base_x + idx*CHAR_W, modulo 2^11.
- char_pos_y  out  11  latched base_y; the ROM stage adds the row index.
- char_valid  out  1  character fields valid; held until char_next.
- char_next  in  1  ROM stage consumed the current character.

Behaviour:
- Reset: all outputs 0; state IDLE; latched config 0. Reset mid-operation aborts immediately with no done pulse.
- States and transitions:
  - IDLE: on start, latch cfg, set idx=0, row=0, x_acc=base_x, busy=1. If clamped len is 0, go to FIN; otherwise go to FETCH.
  - FETCH: text_rd_en=1 and text_rd_addr=idx for exactly one cycle, then go to CAPT.
  - CAPT: register text_rd_data into char_ascii. Drive char_row_index=row, char_pos_x=x_acc, char_pos_y=base_y. Set char_valid=1 (visible next cycle). Go to PRESENT.
  - PRESENT: hold all char_* stable while char_valid=1. On char_next=1, clear char_valid next cycle and advance:
    - If idx<len-1: idx+1, x_acc+=CHAR_W, go to FETCH.
    - Else if row<CHAR_H-1: idx=0, x_acc=base_x, row+1, go to FETCH.
    - Else go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Latency: start at cycle T gives text_rd_en at T+1 and char_valid at T+3. char_next at cycle N gives char_valid=0 at N+1 and the next char_valid at N+3.
- char_valid is always low for at least 2 cycles between characters; the ROM stage needs a rising edge to launch each fetch.
- char_next is ignored unless the state is PRESENT and char_valid=1.
- start arriving in the same cycle as FIN is ignored; it is accepted only in IDLE.
- x_acc wraps at 11 bits with no saturation. row and idx never exceed their ranges.
- Text RAM is read once per character per row, so CHAR_H*len reads per string.

Optional Feature:
- Macro: OSD_SKIP_BLANK_EN.
- Defined: in CAPT, a code outside 33..126 is not presented (char_valid stays 0). The sequencer advances idx/row/x_acc exactly as if char_next had arrived and goes to FETCH or FIN. A string that is entirely blank produces no char_valid and still pulses done.
- Undefined: every character is presented regardless of code.

Test Plan:
- len=3, text "ABC", base (100,50), char_next 2 cycles after each char_valid: exactly 54 presentations, first three with pos_x 100,109,118 and row 0. The last presentation is 'C' with row 17 and pos_x 118; char_pos_y is 50 throughout; done is a single pulse.
- Timing: start at cycle 10, char_next held at 1: text_rd_en at 11, char_valid at 13, char_valid low at 14–15, next char_valid at 16.
- cfg_len=0: done at T+1, busy low, no text_rd_en and no char_valid. cfg_len=100 with MAX_CHARS=64: 64*18 presentations.
- Second start pulse during busy and char_next pulses while char_valid=0: no effect on sequence or counts. base_x=2040, len=2: second char pos_x = 1 (wrap).
- resetn low during PRESENT at row 5: next cycle all outputs 0, no done. A new start afterwards replays from row 0, idx 0.
- OSD_SKIP_BLANK_EN, text "A B": 36 presentations (only 'A' and 'B'), with 'B' at pos_x base+18. Without the macro: 54 presentations, including the space.
